// File: rtl/rv_addr_line_en_target_regs.sv
// Purpose: target end of the rv_addr_line_en interface backed by a small register bank (reg 0 = access counter).
// Latency: ready asserts WAIT_CYCLES+1 cycles after the first valid cycle; one IDLE cycle separates acks.
// Backpressure: the target stalls the initiator by withholding ready; dropping valid before the ack aborts.
module rv_addr_line_en_target_regs #(
  parameter int ADR_WIDTH   = 4,
  parameter int DAT_WIDTH   = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [DAT_WIDTH-1:0] dat_w,
  input  logic                 we,
  input  logic                 valid,
  output logic                 ready,
  output logic [DAT_WIDTH-1:0] dat_r,
  output logic                 wr_pulse,
  output logic [ADR_WIDTH-1:0] wr_adr
);

  localparam int DEPTH = 1 << ADR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  // Counter is loaded with WAIT_CYCLES-1 so that a zero count means "ack next edge".
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]           state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [DAT_WIDTH-1:0] regs_q [DEPTH];
  logic [DAT_WIDTH-1:0] regs_d [DEPTH];
  logic                 wr_pulse_q, wr_pulse_d;
  logic [ADR_WIDTH-1:0] wr_adr_q, wr_adr_d;

  logic ack;
  logic store_wr;

  assign ack      = (state_q == ST_ACK);
  // Register 0 is the counter: writes to it are acked but never stored or strobed.
  assign store_wr = ack && we && (adr != '0);

  // Handshake FSM: IDLE -> (WAIT) -> ACK -> IDLE; valid dropping during WAIT aborts.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!valid) begin
          state_d = ST_IDLE;
          wcnt_d  = 4'd0;
        end else if (wcnt_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        wcnt_d  = 4'd0;
      end
    endcase
  end

  // Register bank update: counter bumps on every ack, storage registers take the write data.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (ack) begin
      regs_d[0] = regs_q[0] + DAT_WIDTH'(1);
    end
    if (store_wr) begin
      regs_d[adr] = dat_w;
    end
  end

  // Write strobe and its address, registered one cycle behind the ack.
  always_comb begin
    wr_pulse_d = store_wr;
    wr_adr_d   = store_wr ? adr : wr_adr_q;
  end

  // State registers; synchronous active-low reset clears everything including the bank.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wcnt_q     <= 4'd0;
      wr_pulse_q <= 1'b0;
      wr_adr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wr_pulse_q <= wr_pulse_d;
      wr_adr_q   <= wr_adr_d;
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read data reflects the pre-update register value and is forced to zero outside ACK.
  always_comb begin
    ready    = ack;
    dat_r    = ack ? regs_q[adr] : '0;
    wr_pulse = wr_pulse_q;
    wr_adr   = wr_adr_q;
  end

endmodule

// File: tb/tb_rv_addr_line_en_target_regs.sv
// Directed bench: three targets (no wait, 3 wait states, 2-bit data for counter wrap).
// Inputs driven on falling edges, outputs sampled on falling edges.
// Every check goes through chk(); summary line reports totals.
module tb_rv_addr_line_en_target_regs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rstn, vld, we;
  logic [2:0][3:0]   adr;
  logic [2:0][31:0]  dw;

  logic        rdy0, rdy1, rdy2;
  logic [31:0] dr0, dr1;
  logic [1:0]  dr2;
  logic        wrp0, wrp1, wrp2;
  logic [3:0]  wra0, wra1, wra2;

  int total = 0;
  int bad   = 0;

  rv_addr_line_en_target_regs #(.ADR_WIDTH(4), .DAT_WIDTH(32), .WAIT_CYCLES(0)) u0 (
    .clock(clk), .reset(rstn[0]), .adr(adr[0]), .dat_w(dw[0]), .we(we[0]), .valid(vld[0]),
    .ready(rdy0), .dat_r(dr0), .wr_pulse(wrp0), .wr_adr(wra0));

  rv_addr_line_en_target_regs #(.ADR_WIDTH(4), .DAT_WIDTH(32), .WAIT_CYCLES(3)) u1 (
    .clock(clk), .reset(rstn[1]), .adr(adr[1]), .dat_w(dw[1]), .we(we[1]), .valid(vld[1]),
    .ready(rdy1), .dat_r(dr1), .wr_pulse(wrp1), .wr_adr(wra1));

  rv_addr_line_en_target_regs #(.ADR_WIDTH(4), .DAT_WIDTH(2), .WAIT_CYCLES(0)) u2 (
    .clock(clk), .reset(rstn[2]), .adr(adr[2]), .dat_w(dw[2][1:0]), .we(we[2]), .valid(vld[2]),
    .ready(rdy2), .dat_r(dr2), .wr_pulse(wrp2), .wr_adr(wra2));

  function automatic logic get_rdy(input int i);
    return (i == 0) ? rdy0 : (i == 1) ? rdy1 : rdy2;
  endfunction

  function automatic logic [31:0] get_dr(input int i);
    return (i == 0) ? dr0 : (i == 1) ? dr1 : {30'd0, dr2};
  endfunction

  function automatic logic get_wrp(input int i);
    return (i == 0) ? wrp0 : (i == 1) ? wrp1 : wrp2;
  endfunction

  function automatic logic [3:0] get_wra(input int i);
    return (i == 0) ? wra0 : (i == 1) ? wra1 : wra2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction; returns read data, latency in cycles, and the strobe seen after the ack.
  task automatic xact(input int i, input logic w, input logic [3:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output int lat, output logic pulse, output logic [3:0] padr);
    @(negedge clk);
    we[i] = w; adr[i] = a; dw[i] = d; vld[i] = 1'b1;
    lat = 0;
    rd  = '0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (get_rdy(i)) break;
    end
    if (!get_rdy(i)) lat = -1;
    rd = get_dr(i);
    vld[i] = 1'b0;
    @(negedge clk);
    pulse = get_wrp(i);
    padr  = get_wra(i);
    chk("idle_dat_r_zero", get_dr(i), 32'd0);
  endtask

  logic [31:0] rd;
  int          lat;
  logic        pl;
  logic [3:0]  pa;
  logic        seen;

  initial begin
    rstn = '0; vld = '0; we = '0; adr = '0; dw = '0;
    repeat (3) @(negedge clk);
    rstn = '1;
    @(negedge clk);

    // reset state
    chk("rst_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_dat_r", dr0, 32'd0);
    chk("rst_wr_pulse", {31'd0, wrp0}, 32'd0);
    chk("rst_wr_adr", {28'd0, wra0}, 32'd0);

    // no-wait target: write then read back
    xact(0, 1'b1, 4'd3, 32'hDEADBEEF, rd, lat, pl, pa);
    chk("w3_lat", 32'(lat), 32'd1);
    chk("w3_pulse", {31'd0, pl}, 32'd1);
    chk("w3_pulse_adr", {28'd0, pa}, 32'd3);
    xact(0, 1'b0, 4'd3, 32'd0, rd, lat, pl, pa);
    chk("r3_lat", 32'(lat), 32'd1);
    chk("r3_data", rd, 32'hDEADBEEF);
    chk("r3_no_pulse", {31'd0, pl}, 32'd0);
    xact(0, 1'b1, 4'd5, 32'h12345678, rd, lat, pl, pa);
    chk("w5_pulse_adr", {28'd0, pa}, 32'd5);
    // counter: three done, read excludes itself
    xact(0, 1'b0, 4'd0, 32'd0, rd, lat, pl, pa);
    chk("cnt_eq3", rd, 32'd3);
    xact(0, 1'b1, 4'd0, 32'h55, rd, lat, pl, pa);
    chk("w0_acked", 32'(lat), 32'd1);
    chk("w0_no_pulse", {31'd0, pl}, 32'd0);
    chk("w0_adr_held", {28'd0, pa}, 32'd5);
    xact(0, 1'b0, 4'd0, 32'd0, rd, lat, pl, pa);
    chk("cnt_eq5", rd, 32'd5);
    xact(0, 1'b0, 4'd5, 32'd0, rd, lat, pl, pa);
    chk("r5_data", rd, 32'h12345678);

    // 3-wait-state target: latency and fresh read
    xact(1, 1'b0, 4'd5, 32'd0, rd, lat, pl, pa);
    chk("ws_r5_lat", 32'(lat), 32'd4);
    chk("ws_r5_data", rd, 32'd0);

    // abort a write by dropping valid in the second WAIT cycle
    @(negedge clk);
    we[1] = 1'b1; adr[1] = 4'd2; dw[1] = 32'hAAAA; vld[1] = 1'b1;
    seen = 1'b0;
    @(negedge clk); seen |= rdy1;
    @(negedge clk); seen |= rdy1;
    vld[1] = 1'b0;
    repeat (5) begin @(negedge clk); seen |= rdy1; end
    chk("abort_no_ready", {31'd0, seen}, 32'd0);
    chk("abort_no_pulse", {31'd0, wrp1}, 32'd0);
    xact(1, 1'b0, 4'd2, 32'd0, rd, lat, pl, pa);
    chk("abort_next_lat", 32'(lat), 32'd4);
    chk("abort_reg_kept", rd, 32'd0);
    xact(1, 1'b0, 4'd0, 32'd0, rd, lat, pl, pa);
    chk("abort_cnt", rd, 32'd2);

    // reset during WAIT of a write to adr 7
    @(negedge clk);
    we[1] = 1'b1; adr[1] = 4'd7; dw[1] = 32'hCAFEF00D; vld[1] = 1'b1;
    seen = 1'b0;
    @(negedge clk); seen |= rdy1;
    @(negedge clk); seen |= rdy1;
    rstn[1] = 1'b0; vld[1] = 1'b0;
    repeat (3) begin @(negedge clk); seen |= rdy1; end
    rstn[1] = 1'b1;
    @(negedge clk); seen |= rdy1;
    chk("rst_abort_no_ready", {31'd0, seen}, 32'd0);
    xact(1, 1'b0, 4'd0, 32'd0, rd, lat, pl, pa);
    chk("rst_abort_lat", 32'(lat), 32'd4);
    chk("rst_abort_cnt", rd, 32'd0);
    xact(1, 1'b0, 4'd7, 32'd0, rd, lat, pl, pa);
    chk("rst_abort_r7", rd, 32'd0);

    // 2-bit counter wraps from 3 to 0
    xact(2, 1'b1, 4'd1, 32'd1, rd, lat, pl, pa);
    xact(2, 1'b1, 4'd1, 32'd2, rd, lat, pl, pa);
    xact(2, 1'b1, 4'd1, 32'd3, rd, lat, pl, pa);
    xact(2, 1'b0, 4'd0, 32'd0, rd, lat, pl, pa);
    chk("wrap_all_ones", rd, 32'd3);
    xact(2, 1'b0, 4'd0, 32'd0, rd, lat, pl, pa);
    chk("wrap_zero", rd, 32'd0);
    xact(2, 1'b0, 4'd0, 32'd0, rd, lat, pl, pa);
    chk("wrap_then_inc", rd, 32'd1);
    xact(2, 1'b0, 4'd1, 32'd0, rd, lat, pl, pa);
    chk("small_r1", rd, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
